// File: rtl/mem_cycle_arbiter_pkg.sv
// Shared constants and helpers for the memory-cycle arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_cycle_arbiter_pkg;

  // Arbiter state encoding; 2'd3 is unused and decodes back to idle.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Cycle counter width; covers CYCLE_LEN up to 255.
  localparam int CNT_W = 8;

  // Width of a requester index. Never less than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_cycle_arbiter_rr_pick.sv
// Round-robin priority scan: first pending index at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; the result is only consumed when the arbiter is idle.
module mem_cycle_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] pending,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  winner,
  output logic            any
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  // Scan ptr, ptr+1, ... modulo NREQ and keep the first hit.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NREQ)) begin
        sum = sum - (IDW+1)'(NREQ);
      end
      idx = sum[IDW-1:0];
      if (!any && pending[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_cycle_arbiter.sv
// Round-robin arbiter granting one requester a fixed-length memory bus cycle.
// Latency: request strobed on tick edge E0 is granted at E1 earliest; grant lasts CYCLE_LEN ticks plus one turnaround tick.
// Backpressure: requests stay latched in pending until their cycle completes; tick=0 freezes all state.
module mem_cycle_arbiter
  import mem_cycle_arbiter_pkg::*;
#(
  parameter int NREQ              = 4,
  parameter int CYCLE_LEN         = 3,
  parameter bit InvertClockEnable = 1'b0
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          tick,
  input  logic [NREQ-1:0]               req_set,
  input  logic                          abort,
  output logic [NREQ-1:0]               pending,
  output logic [NREQ-1:0]               grant,
  output logic [id_width(NREQ)-1:0]     grant_id,
  output logic                          busy,
  output logic                          cyc_start,
  output logic                          cyc_done
);

  localparam int IDW = id_width(NREQ);

  logic             state_clk;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   winner;
  logic             any;
  logic             start_go;
  logic             done_go;

  // Optional falling-edge operation for timing chains clocked off the other edge.
  assign state_clk = InvertClockEnable ? ~clock : clock;

  mem_cycle_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .pending (pending),
    .ptr     (ptr),
    .winner  (winner),
    .any     (any)
  );

  // A grant is issued when idle with something pending, released on timeout or abort.
  assign start_go = tick && (state == ST_IDLE) && any;
  assign done_go  = tick && (state == ST_BUSY) && (abort || (cnt == '0));

  // Per-requester J-K pending latch; a new strobe beats the clear so it re-pends.
  for (genvar i = 0; i < NREQ; i++) begin : g_pend
    logic pend_q;
    logic clr;

    assign clr        = done_go && (grant_id == IDW'(i));
    assign pending[i] = pend_q;

    // Latch update only on tick; req_set is ignored while stalled.
    always_ff @(posedge state_clk or negedge reset_n) begin
      if (!reset_n) begin
        pend_q <= 1'b0;
      end else if (tick) begin
        pend_q <= req_set[i] | (pend_q & ~clr);
      end
    end
  end

  // Arbiter FSM: IDLE picks a winner, BUSY counts the cycle down, DONE is bus turnaround.
  always_ff @(posedge state_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ptr      <= '0;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else if (tick) begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            state    <= ST_BUSY;
            cnt      <= CNT_W'(CYCLE_LEN - 1);
            grant    <= NREQ'(1) << winner;
            grant_id <= winner;
            busy     <= 1'b1;
            ptr      <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
          end
        end
        ST_BUSY: begin
          if (done_go) begin
            state <= ST_DONE;
            grant <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Edge strobes last one clock and self-clear even while tick is low.
  always_ff @(posedge state_clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_start <= 1'b0;
      cyc_done  <= 1'b0;
    end else begin
      cyc_start <= start_go;
      cyc_done  <= done_go;
    end
  end

endmodule

// File: tb/tb_mem_cycle_arbiter.sv
// Directed vector bench for mem_cycle_arbiter (NREQ=4, CYCLE_LEN=3).
// Latency: each table row is one clock; outputs sampled 1 time unit after the rising edge.
// Backpressure: n/a.
module tb_mem_cycle_arbiter;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick    = 1'b0;
  logic       abort   = 1'b0;
  logic [3:0] req_set = 4'b0000;
  logic [3:0] pending;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       cyc_start;
  logic       cyc_done;

  int errors = 0;
  int checks = 0;

  mem_cycle_arbiter #(
    .NREQ              (4),
    .CYCLE_LEN         (3),
    .InvertClockEnable (1'b0)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .tick      (tick),
    .req_set   (req_set),
    .abort     (abort),
    .pending   (pending),
    .grant     (grant),
    .grant_id  (grant_id),
    .busy      (busy),
    .cyc_start (cyc_start),
    .cyc_done  (cyc_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      tag;
    logic       rst;
    logic       tk;
    logic [3:0] rq;
    logic       ab;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [12:0] mk(logic [3:0] p, logic [3:0] g, int gid, logic b, logic cs, logic cd);
    return {p, g, 2'(gid), b, cs, cd};
  endfunction

  function automatic void add(string tag, logic r, logic t, logic [3:0] rq, logic ab,
                              logic [3:0] p, logic [3:0] g, int gid, logic b, logic cs, logic cd);
    vec_t v;
    v.tag = tag; v.rst = r; v.tk = t; v.rq = rq; v.ab = ab;
    v.exp = mk(p, g, gid, b, cs, cd);
    tbl.push_back(v);
  endfunction

  function automatic logic [12:0] outs();
    return {pending, grant, grant_id, busy, cyc_start, cyc_done};
  endfunction

  task automatic check_out(string nm, logic [12:0] act, logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got pend=%b gnt=%b gid=%0d busy=%b cs=%b cd=%b, want pend=%b gnt=%b gid=%0d busy=%b cs=%b cd=%b",
               nm, act[12:9], act[8:5], act[4:3], act[2], act[1], act[0],
               exp[12:9], exp[8:5], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Pulse reset between edges, leaving inputs idle.
  task automatic do_reset();
    @(negedge clock);
    tick = 1'b0; req_set = 4'b0000; abort = 1'b0;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic step(logic t, logic [3:0] rq, logic ab);
    @(negedge clock);
    tick = t; req_set = rq; abort = ab;
    @(posedge clock);
    #1;
  endtask

  logic got;
  logic saw_grant;

  initial begin
    // Single request to requester 1: set, grant next tick, 3 busy ticks, done, turnaround.
    add("single_set",  1, 1, 4'b0010, 0, 4'b0010, 4'b0000, 0, 0, 0, 0);
    add("single_gnt",  0, 1, 4'b0000, 0, 4'b0010, 4'b0010, 1, 1, 1, 0);
    add("single_b2",   0, 1, 4'b0000, 0, 4'b0010, 4'b0010, 1, 1, 0, 0);
    add("single_b3",   0, 1, 4'b0000, 0, 4'b0010, 4'b0010, 1, 1, 0, 0);
    add("single_done", 0, 1, 4'b0000, 0, 4'b0000, 4'b0000, 1, 0, 0, 1);
    add("single_turn", 0, 1, 4'b0000, 0, 4'b0000, 4'b0000, 1, 0, 0, 0);
    add("single_idle", 0, 1, 4'b0000, 0, 4'b0000, 4'b0000, 1, 0, 0, 0);
    // Tick gating: request 3 (ptr=2), stall 5 clocks mid-busy with strobes on req_set.
    add("gate_set",    0, 1, 4'b1000, 0, 4'b1000, 4'b0000, 1, 0, 0, 0);
    add("gate_gnt",    0, 1, 4'b0000, 0, 4'b1000, 4'b1000, 3, 1, 1, 0);
    add("gate_st0",    0, 0, 4'b0001, 0, 4'b1000, 4'b1000, 3, 1, 0, 0);
    add("gate_st1",    0, 0, 4'b0111, 0, 4'b1000, 4'b1000, 3, 1, 0, 0);
    add("gate_st2",    0, 0, 4'b0000, 1, 4'b1000, 4'b1000, 3, 1, 0, 0);
    add("gate_st3",    0, 0, 4'b0110, 0, 4'b1000, 4'b1000, 3, 1, 0, 0);
    add("gate_st4",    0, 0, 4'b0001, 0, 4'b1000, 4'b1000, 3, 1, 0, 0);
    add("gate_b2",     0, 1, 4'b0000, 0, 4'b1000, 4'b1000, 3, 1, 0, 0);
    add("gate_b3",     0, 1, 4'b0000, 0, 4'b1000, 4'b1000, 3, 1, 0, 0);
    add("gate_done",   0, 1, 4'b0000, 0, 4'b0000, 4'b0000, 3, 0, 0, 1);
    add("gate_cdclr",  0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 3, 0, 0, 0);
    add("gate_turn",   0, 1, 4'b0000, 0, 4'b0000, 4'b0000, 3, 0, 0, 0);
    // Round robin with all requests held: 5 ticks per grant, rotation 0,1,2,3,0.
    add("rr_set",      1, 1, 4'b1111, 0, 4'b1111, 4'b0000, 0, 0, 0, 0);
    for (int g = 0; g < 5; g++) begin
      int w;
      logic [3:0] oh;
      w  = g % 4;
      oh = 4'b0001 << w;
      add("rr_gnt",  0, 1, 4'b1111, 0, 4'b1111, oh,      w, 1, 1, 0);
      add("rr_b2",   0, 1, 4'b1111, 0, 4'b1111, oh,      w, 1, 0, 0);
      add("rr_b3",   0, 1, 4'b1111, 0, 4'b1111, oh,      w, 1, 0, 0);
      add("rr_done", 0, 1, 4'b1111, 0, 4'b1111, 4'b0000, w, 0, 0, 1);
      add("rr_turn", 0, 1, 4'b1111, 0, 4'b1111, 4'b0000, w, 0, 0, 0);
    end
    // Wrap-around: grant 2 (ptr->3), then pending 0101 must go 0 before 2.
    add("wrap_set",    1, 1, 4'b0100, 0, 4'b0100, 4'b0000, 0, 0, 0, 0);
    add("wrap_g2",     0, 1, 4'b0000, 0, 4'b0100, 4'b0100, 2, 1, 1, 0);
    add("wrap_req0",   0, 1, 4'b0001, 0, 4'b0101, 4'b0100, 2, 1, 0, 0);
    add("wrap_b3",     0, 1, 4'b0000, 0, 4'b0101, 4'b0100, 2, 1, 0, 0);
    add("wrap_done2",  0, 1, 4'b0100, 0, 4'b0101, 4'b0000, 2, 0, 0, 1);
    add("wrap_turn",   0, 1, 4'b0000, 0, 4'b0101, 4'b0000, 2, 0, 0, 0);
    add("wrap_g0",     0, 1, 4'b0000, 0, 4'b0101, 4'b0001, 0, 1, 1, 0);
    add("wrap_b2",     0, 1, 4'b0000, 0, 4'b0101, 4'b0001, 0, 1, 0, 0);
    add("wrap_b3b",    0, 1, 4'b0000, 0, 4'b0101, 4'b0001, 0, 1, 0, 0);
    add("wrap_done0",  0, 1, 4'b0000, 0, 4'b0100, 4'b0000, 0, 0, 0, 1);
    add("wrap_turn2",  0, 1, 4'b0000, 0, 4'b0100, 4'b0000, 0, 0, 0, 0);
    add("wrap_g2b",    0, 1, 4'b0000, 0, 4'b0100, 4'b0100, 2, 1, 1, 0);
    add("wrap_b2c",    0, 1, 4'b0000, 0, 4'b0100, 4'b0100, 2, 1, 0, 0);
    add("wrap_b3c",    0, 1, 4'b0000, 0, 4'b0100, 4'b0100, 2, 1, 0, 0);
    add("wrap_done2b", 0, 1, 4'b0000, 0, 4'b0000, 4'b0000, 2, 0, 0, 1);
    // Abort raised after the first countdown: grant held 2 ticks; abort ignored outside busy.
    add("abt_set",     1, 1, 4'b0001, 0, 4'b0001, 4'b0000, 0, 0, 0, 0);
    add("abt_gnt",     0, 1, 4'b0000, 0, 4'b0001, 4'b0001, 0, 1, 1, 0);
    add("abt_b2",      0, 1, 4'b0000, 0, 4'b0001, 4'b0001, 0, 1, 0, 0);
    add("abt_done",    0, 1, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 0, 1);
    add("abt_turn",    0, 1, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
    add("abt_idle",    0, 1, 4'b0010, 1, 4'b0010, 4'b0000, 0, 0, 0, 0);
    add("abt_igngnt",  0, 1, 4'b0000, 1, 4'b0010, 4'b0010, 1, 1, 1, 0);
    add("abt_b2b",     0, 1, 4'b0000, 0, 4'b0010, 4'b0010, 1, 1, 0, 0);
    add("abt_b3b",     0, 1, 4'b0000, 0, 4'b0010, 4'b0010, 1, 1, 0, 0);
    add("abt_doneb",   0, 1, 4'b0000, 0, 4'b0000, 4'b0000, 1, 0, 0, 1);

    // Power-up reset state.
    #3;
    check_out("reset_state", outs(), mk(4'b0000, 4'b0000, 0, 0, 0, 0));
    @(negedge clock);
    reset_n = 1'b1;

    foreach (tbl[k]) begin
      if (tbl[k].rst) begin
        do_reset();
      end else begin
        @(negedge clock);
      end
      tick = tbl[k].tk; req_set = tbl[k].rq; abort = tbl[k].ab;
      @(posedge clock);
      #1;
      check_out($sformatf("%s[%0d]", tbl[k].tag, k), outs(), tbl[k].exp);
    end

    // Reset asserted mid-busy clears everything at once, and nothing resumes afterwards.
    do_reset();
    step(1'b1, 4'b0100, 1'b0);
    step(1'b1, 4'b0000, 1'b0);
    check_out("rst_pre_grant", outs(), mk(4'b0100, 4'b0100, 2, 1, 1, 0));
    step(1'b1, 4'b0000, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_out("rst_async", outs(), mk(4'b0000, 4'b0000, 0, 0, 0, 0));
    @(negedge clock);
    tick = 1'b1; req_set = 4'b0000;
    @(posedge clock);
    #1;
    check_out("rst_held", outs(), mk(4'b0000, 4'b0000, 0, 0, 0, 0));
    #1;
    reset_n = 1'b1;
    saw_grant = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 4'b0000, 1'b0);
      if ((grant != 4'b0000) || busy || cyc_start || (pending != 4'b0000)) saw_grant = 1'b1;
    end
    checks++;
    if (saw_grant) begin
      errors++;
      $display("FAIL rst_no_resume: got activity after reset release, want none");
    end
    step(1'b1, 4'b1000, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      step(1'b1, 4'b0000, 1'b0);
      if (grant != 4'b0000) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL rst_regrant: got no grant within 10 ticks, want grant 1000");
    end else begin
      check_out("rst_regrant", outs(), mk(4'b1000, 4'b1000, 3, 1, 1, 0));
    end

    tick = 1'b0; req_set = 4'b0000; abort = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
